// File: rtl/prover_interpolate_poly.sv
// -----------------------------------------------------------------------------
// prover_interpolate_poly
//
// Recovers the monomial coefficients c_0..c_DEGREE of the unique polynomial p
// (deg p <= DEGREE) over F_Q from its evaluations y_i = p(i), i = 0..DEGREE.
// Used by the sumcheck prover for rounds whose polynomial degree exceeds 2.
//
// The work is done iteratively through one shared field multiply-subtract
// unit, one field operation per cycle:
//   DIFF  : in-place forward differences, leaving d[k] = Delta^k y_0
//   SCALE : d[k] *= (k!)^-1, turning differences into Newton coefficients
//   CONV  : Newton (falling-factorial) basis -> monomial basis, Horner style
// A job takes N_OPS = D(D+1) + 2D - 1 cycles after the start edge.
//
// Handshake: `ready` is high exactly while the block is idle; `en` is only
// sampled while ready=1, and y_in is captured on that edge alone. On the
// completion edge c_out is loaded, ready rises and ready_pulse strobes for
// one cycle. c_out changes only on completion edges (and on reset).
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rstb         in   asynchronous active-low reset
//   en           in   start request, sampled only while ready=1
//   y_in         in   [DEGREE:0][F_NBITS]  y_in[i] = p(i), each < F_Q
//   c_out        out  [DEGREE:0][F_NBITS]  c_out[j] = coefficient of x^j
//   ready        out  idle, c_out valid
//   ready_pulse  out  one-cycle strobe on completion
//   state_dbg    out  current FSM state (IDLE=0, DIFF=1, SCALE=2, CONV=3)
// -----------------------------------------------------------------------------

`ifndef F_NBITS
`define F_NBITS 31
`endif
`ifndef F_Q
`define F_Q 2147483647
`endif

module prover_interpolate_poly #(
   parameter int DEGREE = 3
) (
   input  logic                          clk,
   input  logic                          rstb,
   input  logic                          en,
   input  logic [DEGREE:0][`F_NBITS-1:0] y_in,
   output logic [DEGREE:0][`F_NBITS-1:0] c_out,
   output logic                          ready,
   output logic                          ready_pulse,
   output logic [1:0]                    state_dbg
);

   localparam int W  = `F_NBITS;
   localparam int D  = DEGREE;
   localparam int IW = $clog2(DEGREE + 1);

   localparam logic [63:0]  Q64 = 64'(`F_Q);
   localparam logic [W-1:0] Q   = W'(`F_Q);

   if (DEGREE < 2 || DEGREE > 15) begin : g_bad_degree
      $error("prover_interpolate_poly: DEGREE must be in 2..15");
   end

   // (k!)^-1 mod Q for k = 2..D via Fermat (x^(Q-2)); entries 0 and 1 unused.
   function automatic logic [DEGREE:0][W-1:0] build_invf();
      logic [DEGREE:0][W-1:0] t;
      logic [63:0]            fact;
      logic [63:0]            base;
      logic [63:0]            res;
      logic [63:0]            e;
      t    = '0;
      fact = 64'd1;
      for (int k = 1; k <= DEGREE; k++) begin
         fact = (fact * 64'(k)) % Q64;
         if (k >= 2) begin
            res  = 64'd1;
            base = fact;
            e    = Q64 - 64'd2;
            for (int b = 0; b < 64; b++) begin
               if (e[b]) res = (res * base) % Q64;
               base = (base * base) % Q64;
            end
            t[k] = W'(res);
         end
      end
      return t;
   endfunction

   localparam logic [DEGREE:0][W-1:0] INVF = build_invf();

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIFF  = 2'd1,
      SCALE = 2'd2,
      CONV  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          k_q, k_d;       // outer loop index
   logic [IW-1:0]          idx_q, idx_d;   // inner index (i in DIFF, j in CONV)
   logic [DEGREE:0][W-1:0] d_q, d_d;
   logic [DEGREE:0][W-1:0] c_q, c_d;
   logic [DEGREE:0][W-1:0] c_out_q, c_out_d;
   logic                   ready_pulse_q, ready_pulse_d;

   // Shared field unit: op_res = op_sub ? (op_a - op_m*op_b) : (op_m*op_b)
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_m;
   logic [W-1:0]   op_b;
   logic           op_sub;
   logic [2*W-1:0] prod;
   logic [W-1:0]   prod_mod;
   logic [W-1:0]   op_res;

   // Operand selection: which field op this cycle performs.
   always_comb begin
      op_a   = '0;
      op_m   = '0;
      op_b   = '0;
      op_sub = 1'b0;
      case (state_q)
         DIFF: begin
            op_a   = d_q[idx_q];
            op_m   = W'(1);
            op_b   = d_q[idx_q - 1'b1];
            op_sub = 1'b1;
         end
         SCALE: begin
            op_m   = INVF[k_q];
            op_b   = d_q[k_q];
         end
         CONV: begin
            op_m   = W'(k_q);
            op_sub = 1'b1;
            if (idx_q != '0) begin
               op_a = c_q[idx_q - 1'b1];
               op_b = c_q[idx_q];
            end else begin
               op_a = d_q[k_q];
               op_b = c_q[0];
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      prod     = {{W{1'b0}}, op_m} * {{W{1'b0}}, op_b};
      prod_mod = W'(prod % {{W{1'b0}}, Q});
      op_res   = prod_mod;
      if (op_sub) begin
         // Both operands are < Q, so a single conditional add of Q suffices.
         if (op_a >= prod_mod) op_res = op_a - prod_mod;
         else                  op_res = (Q - prod_mod) + op_a;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      idx_d         = idx_q;
      d_d           = d_q;
      c_d           = c_q;
      c_out_d       = c_out_q;
      ready_pulse_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               d_d     = y_in;
               k_d     = IW'(1);
               idx_d   = IW'(D);
               state_d = DIFF;
            end
         end
         DIFF: begin
            // for k = 1..D, i = D downto k: d[i] -= d[i-1]
            d_d[idx_q] = op_res;
            if (idx_q == k_q) begin
               if (k_q == IW'(D)) begin
                  k_d     = IW'(D);
                  state_d = SCALE;
               end else begin
                  k_d   = k_q + 1'b1;
                  idx_d = IW'(D);
               end
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         SCALE: begin
            // for k = D downto 2: d[k] *= INVF[k]
            d_d[k_q] = op_res;
            if (k_q == IW'(2)) begin
               // Seed the Newton-to-monomial conversion with the top
               // coefficient. When D=2 the top term is being scaled on this
               // very edge, so take the freshly computed value.
               c_d     = '0;
               c_d[0]  = (k_q == IW'(D)) ? op_res : d_q[D];
               k_d     = IW'(D - 1);
               idx_d   = IW'(1);
               state_d = CONV;
            end else begin
               k_d = k_q - 1'b1;
            end
         end
         CONV: begin
            // for k = D-1 downto 0: multiply c by (x - k), then add d[k].
            if (idx_q != '0) begin
               c_d[idx_q] = op_res;
               idx_d      = idx_q - 1'b1;
            end else begin
               c_d[0] = op_res;
               if (k_q == '0) begin
                  c_out_d       = c_d;
                  ready_pulse_d = 1'b1;
                  state_d       = IDLE;
               end else begin
                  k_d   = k_q - 1'b1;
                  idx_d = IW'(D) - k_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q       <= IDLE;
         k_q           <= '0;
         idx_q         <= '0;
         d_q           <= '0;
         c_q           <= '0;
         c_out_q       <= '0;
         ready_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         idx_q         <= idx_d;
         d_q           <= d_d;
         c_q           <= c_d;
         c_out_q       <= c_out_d;
         ready_pulse_q <= ready_pulse_d;
      end
   end

   assign c_out       = c_out_q;
   assign ready       = (state_q == IDLE);
   assign ready_pulse = ready_pulse_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_prover_interpolate_poly.sv
// -----------------------------------------------------------------------------
// tb_prover_interpolate_poly
//
// Drives three instances (DEGREE = 2, 3, 5). Expected coefficients come from
// Lagrange interpolation over F_Q computed in the bench; each completion is
// also Horner-evaluated at x = 0..D and compared to the y that was issued.
// -----------------------------------------------------------------------------

`ifndef F_NBITS
`define F_NBITS 31
`endif
`ifndef F_Q
`define F_Q 2147483647
`endif

module tb_prover_interpolate_poly;

   localparam int W = `F_NBITS;
   localparam longint unsigned Q = 64'(`F_Q);

   typedef logic [5:0][W-1:0] coef_t;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rstb;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   logic              en2, rdy2, pl2;
   logic [2:0][W-1:0] y2, c2;
   logic [1:0]        st2;
   logic              en3, rdy3, pl3;
   logic [3:0][W-1:0] y3, c3;
   logic [1:0]        st3;
   logic              en5, rdy5, pl5;
   logic [5:0][W-1:0] y5, c5;
   logic [1:0]        st5;

   prover_interpolate_poly #(.DEGREE(2)) u_d2 (
      .clk(clk), .rstb(rstb), .en(en2), .y_in(y2), .c_out(c2),
      .ready(rdy2), .ready_pulse(pl2), .state_dbg(st2));
   prover_interpolate_poly #(.DEGREE(3)) u_d3 (
      .clk(clk), .rstb(rstb), .en(en3), .y_in(y3), .c_out(c3),
      .ready(rdy3), .ready_pulse(pl3), .state_dbg(st3));
   prover_interpolate_poly #(.DEGREE(5)) u_d5 (
      .clk(clk), .rstb(rstb), .en(en5), .y_in(y5), .c_out(c5),
      .ready(rdy5), .ready_pulse(pl5), .state_dbg(st5));

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   coef_t exp_q2[$], exp_q3[$], exp_q5[$];
   coef_t yq2[$], yq3[$], yq5[$];

   task automatic check(input string name, input logic ok,
                        input logic [6*W-1:0] act, input logic [6*W-1:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   // ---------------- reference model ----------------
   function automatic longint unsigned mmul(input longint unsigned a, input longint unsigned b);
      return (a * b) % Q;
   endfunction

   function automatic longint unsigned msub(input longint unsigned a, input longint unsigned b);
      return (a + Q - b) % Q;
   endfunction

   function automatic longint unsigned mpow(input longint unsigned b, input longint unsigned e);
      longint unsigned r = 1;
      longint unsigned x = b;
      for (int i = 0; i < 64; i++) begin
         if (e[i]) r = mmul(r, x);
         x = mmul(x, x);
      end
      return r;
   endfunction

   // Lagrange: p(x) = sum_i y_i * prod_{j!=i} (x-j)/(i-j)
   function automatic coef_t model_coefs(input int deg, input coef_t y);
      longint unsigned acc[6];
      longint unsigned basis[6];
      longint unsigned den, s, prev;
      coef_t           out;
      for (int t = 0; t < 6; t++) acc[t] = 0;
      for (int i = 0; i <= deg; i++) begin
         for (int t = 0; t < 6; t++) basis[t] = 0;
         basis[0] = 1;
         den      = 1;
         for (int j = 0; j <= deg; j++) begin
            if (j != i) begin
               for (int t = 5; t >= 0; t--) begin
                  if (t > 0) prev = basis[t-1];
                  else       prev = 0;
                  basis[t] = msub(prev, mmul(longint'(j), basis[t]));
               end
               if (i > j) den = mmul(den, longint'(i - j));
               else       den = mmul(den, Q - longint'(j - i));
            end
         end
         s = mmul(longint'(y[i]), mpow(den, Q - 2));
         for (int t = 0; t < 6; t++) acc[t] = (acc[t] + mmul(basis[t], s)) % Q;
      end
      out = '0;
      for (int t = 0; t <= deg; t++) out[t] = W'(acc[t]);
      return out;
   endfunction

   function automatic longint unsigned horner(input int deg, input coef_t c, input int x);
      longint unsigned v = 0;
      for (int t = deg; t >= 0; t--) v = (mmul(v, longint'(x)) + longint'(c[t])) % Q;
      return v;
   endfunction

   function automatic int nops(input int deg);
      return deg * (deg + 1) + 2 * deg - 1;
   endfunction

   // ---------------- DUT access helpers ----------------
   function automatic coef_t get_c(input int deg);
      coef_t r = '0;
      case (deg)
         2:       for (int j = 0; j <= 2; j++) r[j] = c2[j];
         3:       for (int j = 0; j <= 3; j++) r[j] = c3[j];
         default: for (int j = 0; j <= 5; j++) r[j] = c5[j];
      endcase
      return r;
   endfunction

   function automatic logic get_pulse(input int deg);
      case (deg)
         2:       return pl2;
         3:       return pl3;
         default: return pl5;
      endcase
   endfunction

   function automatic logic get_ready(input int deg);
      case (deg)
         2:       return rdy2;
         3:       return rdy3;
         default: return rdy5;
      endcase
   endfunction

   function automatic coef_t rand_y(input int deg);
      coef_t   y = '0;
      int unsigned r;
      for (int j = 0; j <= deg; j++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      y[j] = '0;
         else if (r == 1) y[j] = W'(Q - 1);
         else             y[j] = W'($urandom_range(0, 32'(Q - 1)));
      end
      return y;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_inputs(input int deg, input logic e, input coef_t y);
      case (deg)
         2: begin en2 = e; for (int j = 0; j <= 2; j++) y2[j] = y[j]; end
         3: begin en3 = e; for (int j = 0; j <= 3; j++) y3[j] = y[j]; end
         default: begin en5 = e; for (int j = 0; j <= 5; j++) y5[j] = y[j]; end
      endcase
   endtask

   task automatic push_exp(input int deg, input coef_t y);
      case (deg)
         2: begin exp_q2.push_back(model_coefs(2, y)); yq2.push_back(y); end
         3: begin exp_q3.push_back(model_coefs(3, y)); yq3.push_back(y); end
         default: begin exp_q5.push_back(model_coefs(5, y)); yq5.push_back(y); end
      endcase
   endtask

   // Start a job; returns #1 after the start edge with y_in scrambled.
   task automatic issue(input int deg, input coef_t y, input bit expect_done);
      @(negedge clk);
      set_inputs(deg, 1'b1, y);
      if (expect_done) push_exp(deg, y);
      @(posedge clk);
      #1;
      set_inputs(deg, 1'b0, rand_y(deg));
   endtask

   // Counts edges after the start edge until ready_pulse; bounded.
   task automatic wait_done(input int deg, input string name);
      int cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (!get_pulse(deg) && cnt < 400);
      check(name, cnt == nops(deg), cnt, nops(deg));
   endtask

   // ---------------- monitors / scoreboard ----------------
   task automatic verify(input string who, input int deg, input coef_t got,
                         input coef_t e, input coef_t y);
      longint unsigned v;
      check({who, " coefs"}, got == e, got, e);
      for (int x = 0; x <= deg; x++) begin
         v = horner(deg, got, x);
         check($sformatf("%s horner x=%0d", who, x), v == longint'(y[x]), v, y[x]);
      end
   endtask

   always @(negedge clk) begin
      if (rstb === 1'b1 && pl2 === 1'b1) begin
         check("d2 pulse with job pending", exp_q2.size() != 0, exp_q2.size(), 1);
         if (exp_q2.size() != 0) verify("d2", 2, get_c(2), exp_q2.pop_front(), yq2.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rstb === 1'b1 && pl3 === 1'b1) begin
         check("d3 pulse with job pending", exp_q3.size() != 0, exp_q3.size(), 1);
         if (exp_q3.size() != 0) verify("d3", 3, get_c(3), exp_q3.pop_front(), yq3.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rstb === 1'b1 && pl5 === 1'b1) begin
         check("d5 pulse with job pending", exp_q5.size() != 0, exp_q5.size(), 1);
         if (exp_q5.size() != 0) verify("d5", 5, get_c(5), exp_q5.pop_front(), yq5.pop_front());
      end
   end

   // Back-to-back jobs: each new en is raised during the ready_pulse cycle.
   task automatic chain(input int deg, input int njobs);
      int    cnt;
      coef_t y;
      issue(deg, rand_y(deg), 1'b1);
      for (int n = 0; n < njobs; n++) begin
         cnt = 0;
         do begin
            @(posedge clk);
            #1;
            cnt++;
         end while (!get_pulse(deg) && cnt < 400);
         check($sformatf("d%0d chain latency job %0d", deg, n), cnt == nops(deg), cnt, nops(deg));
         if (n < njobs - 1) begin
            y = rand_y(deg);
            set_inputs(deg, 1'b1, y);
            push_exp(deg, y);
            @(posedge clk);
            #1;
            set_inputs(deg, 1'b0, rand_y(deg));
         end
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      coef_t y, ex;
      int    pulses, first_at;

      rstb = 1'b0;
      set_inputs(2, 1'b0, '0);
      set_inputs(3, 1'b0, '0);
      set_inputs(5, 1'b0, '0);
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      check("reset ready d2", rdy2 == 1'b1, rdy2, 1);
      check("reset ready d3", rdy3 == 1'b1, rdy3, 1);
      check("reset ready d5", rdy5 == 1'b1, rdy5, 1);
      check("reset pulse d3", pl3 == 1'b0, pl3, 0);
      check("reset c_out d3", get_c(3) == '0, get_c(3), 0);
      check("reset c_out d5", get_c(5) == '0, get_c(5), 0);
      @(negedge clk);
      rstb = 1'b1;

      // 1. D=2, y=(1,4,9) -> (1,2,1) after 9 cycles
      y = '0; y[0] = 1; y[1] = 4; y[2] = 9;
      issue(2, y, 1'b1);
      check("t1 ready low while busy", rdy2 == 1'b0, rdy2, 0);
      wait_done(2, "t1 latency");
      ex = '0; ex[0] = 1; ex[1] = 2; ex[2] = 1;
      check("t1 c_out", get_c(2) == ex, get_c(2), ex);
      check("t1 ready at done", rdy2 == 1'b1, rdy2, 1);
      @(posedge clk);
      #1;
      check("t1 pulse one cycle", pl2 == 1'b0, pl2, 0);

      // 2. D=3 cubes, then constant 5
      y = '0; y[0] = 0; y[1] = 1; y[2] = 8; y[3] = 27;
      issue(3, y, 1'b1);
      wait_done(3, "t2 latency cube");
      ex = '0; ex[3] = 1;
      check("t2 c_out cube", get_c(3) == ex, get_c(3), ex);
      y = '0; y[0] = 5; y[1] = 5; y[2] = 5; y[3] = 5;
      issue(3, y, 1'b1);
      wait_done(3, "t2 latency const");
      ex = '0; ex[0] = 5;
      check("t2 c_out const", get_c(3) == ex, get_c(3), ex);

      // 3. D=2, p = -x: modular wrap
      y = '0; y[0] = 0; y[1] = W'(Q - 1); y[2] = W'(Q - 2);
      issue(2, y, 1'b1);
      wait_done(2, "t3 latency");
      ex = '0; ex[1] = W'(Q - 1);
      check("t3 c_out", get_c(2) == ex, get_c(2), ex);

      // 4. en pulses while busy are ignored
      issue(3, rand_y(3), 1'b1);
      pulses   = 0;
      first_at = 0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         set_inputs(3, (cyc == 3 || cyc == 8), rand_y(3));
         @(posedge clk);
         #1;
         if (pl3) begin
            pulses++;
            if (first_at == 0) first_at = cyc;
         end
      end
      check("t4 pulse count", pulses == 1, pulses, 1);
      check("t4 pulse cycle", first_at == nops(3), first_at, nops(3));

      // 5. reset during a job aborts it
      issue(3, rand_y(3), 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rstb = 1'b0;
      #1;
      check("t5 ready after abort", rdy3 == 1'b1, rdy3, 1);
      check("t5 c_out after abort", get_c(3) == '0, get_c(3), 0);
      check("t5 pulse after abort", pl3 == 1'b0, pl3, 0);
      @(negedge clk);
      rstb = 1'b1;
      pulses = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(posedge clk);
         #1;
         if (pl3) pulses++;
      end
      check("t5 no pulse after abort", pulses == 0, pulses, 0);
      issue(3, rand_y(3), 1'b1);
      wait_done(3, "t5 latency after abort");

      // 6. randomized back-to-back jobs
      chain(2, 8);
      chain(3, 8);
      chain(5, 8);

      repeat (5) @(posedge clk);
      #1;
      check("d2 queue drained", exp_q2.size() == 0, exp_q2.size(), 0);
      check("d3 queue drained", exp_q3.size() == 0, exp_q3.size(), 0);
      check("d5 queue drained", exp_q5.size() == 0, exp_q5.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
